bcd_field_editor: RTL and testbench
===================================

BCD_FIELD_EDITOR -- requirements
Module: bcd_field_editor

Interface
REQ-001 SHALL have parameter NFIELD, default 3; number of 2-digit BCD fields, range 1..8.
REQ-002 SHALL have parameter MAXV, default {8'h23,8'h59,8'h59}; packed 8*NFIELD BCD per-field maximum.
REQ-003 SHALL have parameter MINV, default all 8'h00; packed 8*NFIELD BCD per-field minimum, with MINV <= MAXV per field.
REQ-004 SHALL have parameter REP_DLY, default 1000; auto-repeat initial delay in cycles.
REQ-005 SHALL have parameter REP_PER, default 200; auto-repeat period in cycles.
REQ-006 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  in  1  edit enable; high holds an edit session.
REQ-009 SHALL have port load_val  in  8*NFIELD  initial value; field 0 occupies the MSBs.
REQ-010 SHALL have ports bt_up, bt_down, bt_l, bt_r  in  1 each  level buttons, already debounced.
REQ-011 SHALL have port edit_val  out  8*NFIELD  working value.
REQ-012 SHALL have port cursor  out  clog2(2*NFIELD)  selected digit; even = tens, odd = units, 0 = field 0 tens.
REQ-013 SHALL have port busy  out  1  high in LOAD and EDIT.
REQ-014 SHALL have port commit  out  1  one-cycle pulse; edit_val is final on that cycle.
REQ-015 SHALL have port load_err  out  1  one-cycle pulse when load_val contained an illegal field.

Function
REQ-016 SHALL implement states IDLE, LOAD, EDIT, COMMIT; IDLE->LOAD on en 0->1; LOAD->EDIT after exactly 1 cycle; EDIT->COMMIT on en=0; COMMIT->IDLE after 1 cycle.
REQ-017 In LOAD, SHALL capture load_val into edit_val and set cursor=0; busy SHALL go high the cycle after en rises.
REQ-018 A field SHALL be illegal if either nibble >9, or value < MINV, or value > MAXV; an illegal field SHALL load as its MINV, with load_err high in the EDIT-entry cycle.
REQ-019 Every button SHALL be edge-detected against a registered previous level, updated in all states, so a button held at session start fires nothing.
REQ-020 In EDIT, a bt_r rising edge SHALL do cursor+1, wrapping 2*NFIELD-1 -> 0; a bt_l rising edge SHALL do cursor-1, wrapping 0 -> 2*NFIELD-1.
REQ-021 In EDIT, a bt_up rising edge SHALL BCD-add the digit weight (10 for tens, 1 for units, carry units->tens) to the selected field; a result > MAXV or above 99 SHALL become MINV.
REQ-022 In EDIT, a bt_down rising edge SHALL BCD-subtract the digit weight; a result < MINV or an underflow SHALL become MAXV.
REQ-023 Simultaneous up+down edges SHALL leave the value unchanged; simultaneous l+r edges SHALL leave the cursor unchanged.
REQ-024 A value step and a cursor move in the same cycle SHALL both apply, with the step using the pre-move cursor.
REQ-025 Each step SHALL be visible on edit_val one cycle after the edge; only the selected field SHALL change.
REQ-026 Buttons SHALL be ignored outside EDIT; edit_val SHALL hold in IDLE and COMMIT.
REQ-027 en falling during LOAD SHALL complete LOAD, then go to COMMIT on the following cycle.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, edit_val=0, cursor=0, busy=0, commit=0, load_err=0, button history=0, repeat counters=0.
REQ-029 Reset mid-session SHALL discard the session with no commit pulse; after reset release, a new en rising edge is required to start a session.

Configuration
REQ-030 With BCD_EDIT_AUTOREPEAT_EN defined, bt_up or bt_down held alone in EDIT SHALL generate one extra step REP_DLY cycles after its edge, then one every REP_PER cycles while held; release, or the other button pressed, SHALL clear the counter.
REQ-031 Without BCD_EDIT_AUTOREPEAT_EN, only edges SHALL step and no repeat counters SHALL be synthesised.

Verification (NFIELD=3, default MAXV/MINV)
REQ-032 load_val=0x125930, en rise -> busy=1 next cycle, edit_val=0x125930, cursor=0, load_err=0.
REQ-033 cursor=1, field0=0x23, bt_up pulse -> 0x00; bt_down pulse -> 0x23; cursor=3, field1=0x19, bt_up -> 0x20.
REQ-034 cursor=0, bt_l pulse -> cursor=5; bt_r pulse -> cursor=0; bt_up+bt_down rising in the same cycle -> edit_val unchanged.
REQ-035 load_val=0x2A6007 -> edit_val=0x000007, load_err one-cycle pulse.
REQ-036 en fall in EDIT -> commit high exactly 1 cycle, busy=0 after; reset=0 mid-EDIT -> all outputs 0 with no clock edge and no commit.
REQ-037 With the macro, REP_DLY=4, REP_PER=2, bt_up held 10 cycles on 0x00 units -> steps at edge, +4, +6, +8 -> 0x04.

Source files
------------

// File: rtl/bcd_field_editor.sv
// rtl/bcd_field_editor.sv - multi-field 2-digit BCD value editor driven by four buttons
//
// Purpose: loads a packed BCD value on an edit-session start, lets the user
// move a digit cursor and step the selected digit up/down with per-field
// min/max wrap, and pulses commit when the session ends.
// Optional feature macro: BCD_EDIT_AUTOREPEAT_EN (hold-to-repeat on up/down).
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   en        in   edit enable; a rising edge starts a session, low ends it
//   load_val  in   8*NFIELD initial value, field 0 in the MSBs
//   bt_up     in   step selected digit up
//   bt_down   in   step selected digit down
//   bt_l      in   cursor left
//   bt_r      in   cursor right
//   edit_val  out  8*NFIELD working value
//   cursor    out  selected digit (even = tens, odd = units, 0 = field 0 tens)
//   busy      out  high in LOAD and EDIT
//   commit    out  one-cycle pulse, edit_val final
//   load_err  out  one-cycle pulse when load_val held an illegal field
module bcd_field_editor #(
  parameter int                  NFIELD  = 3,
  parameter logic [8*NFIELD-1:0] MAXV    = {8'h23, 8'h59, 8'h59},
  parameter logic [8*NFIELD-1:0] MINV    = '0,
  parameter int                  REP_DLY = 1000,
  parameter int                  REP_PER = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [8*NFIELD-1:0]           load_val,
  input  logic                          bt_up,
  input  logic                          bt_down,
  input  logic                          bt_l,
  input  logic                          bt_r,
  output logic [8*NFIELD-1:0]           edit_val,
  output logic [$clog2(2*NFIELD)-1:0]   cursor,
  output logic                          busy,
  output logic                          commit,
  output logic                          load_err
);

  localparam int                CUR_W    = $clog2(2*NFIELD);
  localparam logic [CUR_W-1:0]  CUR_LAST = CUR_W'(2*NFIELD-1);

  if (NFIELD < 1 || NFIELD > 8 || REP_DLY < 1 || REP_PER < 1) begin : g_param_chk
    $error("bcd_field_editor: NFIELD must be 1..8 and REP_DLY/REP_PER at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic                en_q;
  logic                up_q, dn_q, l_q, r_q;
  logic [8*NFIELD-1:0] val_q, val_d;
  logic [CUR_W-1:0]    cur_q, cur_d;
  logic                err_q, err_d;

  logic up_e, dn_e, l_e, r_e;
  logic rep_up, rep_dn;

  assign up_e = bt_up   & ~up_q;
  assign dn_e = bt_down & ~dn_q;
  assign l_e  = bt_l    & ~l_q;
  assign r_e  = bt_r    & ~r_q;

  // Load sanitising: any field with a non-decimal nibble or outside its
  // min/max window is replaced by that field's minimum.
  logic [8*NFIELD-1:0] load_clean;
  logic                load_bad;

  always_comb begin
    load_clean = load_val;
    load_bad   = 1'b0;
    for (int i = 0; i < NFIELD; i++) begin
      logic [7:0] fld;
      fld = load_val[8*i +: 8];
      if (fld[7:4] > 4'd9 || fld[3:0] > 4'd9 ||
          fld < MINV[8*i +: 8] || fld > MAXV[8*i +: 8]) begin
        load_clean[8*i +: 8] = MINV[8*i +: 8];
        load_bad             = 1'b1;
      end
    end
  end

  // Digit stepping on the field under the cursor. Stored fields are always
  // legal BCD, so unsigned byte compares order them numerically.
  int         sel;
  int         off;
  logic [7:0] fld_cur, min_f, max_f, up_fld, dn_fld;
  logic [3:0] hi, lo;
  logic       ovf, unf;

  always_comb begin
    sel     = int'(cur_q) >> 1;
    off     = 8 * (NFIELD - 1 - sel);
    fld_cur = val_q[off +: 8];
    min_f   = MINV[off +: 8];
    max_f   = MAXV[off +: 8];
    hi      = fld_cur[7:4];
    lo      = fld_cur[3:0];

    up_fld = fld_cur;
    ovf    = 1'b0;
    if (!cur_q[0]) begin
      if (hi == 4'd9) ovf = 1'b1;
      else            up_fld = {hi + 4'd1, lo};
    end else if (lo == 4'd9) begin
      if (hi == 4'd9) ovf = 1'b1;
      else            up_fld = {hi + 4'd1, 4'd0};
    end else begin
      up_fld = {hi, lo + 4'd1};
    end
    if (ovf || up_fld > max_f) up_fld = min_f;

    dn_fld = fld_cur;
    unf    = 1'b0;
    if (!cur_q[0]) begin
      if (hi == 4'd0) unf = 1'b1;
      else            dn_fld = {hi - 4'd1, lo};
    end else if (lo == 4'd0) begin
      if (hi == 4'd0) unf = 1'b1;
      else            dn_fld = {hi - 4'd1, 4'd9};
    end else begin
      dn_fld = {hi, lo - 4'd1};
    end
    if (unf || dn_fld < min_f) dn_fld = max_f;
  end

`ifdef BCD_EDIT_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RC_W    = $clog2(REP_MAX + 1);

  // rcnt counts cycles since the last step of the held button; zero means
  // disarmed. rfirst selects the initial delay versus the repeat period.
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic            rfirst_q, rfirst_d;
  logic            rdir_q, rdir_d;

  always_comb begin
    rcnt_d   = '0;
    rfirst_d = 1'b0;
    rdir_d   = rdir_q;
    rep_up   = 1'b0;
    rep_dn   = 1'b0;
    if (state_q == S_EDIT) begin
      if (up_e && !bt_down) begin
        rcnt_d   = RC_W'(1);
        rfirst_d = 1'b1;
        rdir_d   = 1'b1;
      end else if (dn_e && !bt_up) begin
        rcnt_d   = RC_W'(1);
        rfirst_d = 1'b1;
        rdir_d   = 1'b0;
      end else if (rcnt_q != '0 &&
                   (rdir_q ? (bt_up && !bt_down) : (bt_down && !bt_up))) begin
        if (rfirst_q ? (rcnt_q == RC_W'(REP_DLY)) : (rcnt_q == RC_W'(REP_PER))) begin
          rep_up = rdir_q;
          rep_dn = !rdir_q;
          rcnt_d = RC_W'(1);
        end else begin
          rcnt_d   = rcnt_q + RC_W'(1);
          rfirst_d = rfirst_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b0;
      rdir_q   <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
      rdir_q   <= rdir_d;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  logic do_up, do_dn;
  assign do_up = (up_e && !dn_e) || rep_up;
  assign do_dn = (dn_e && !up_e) || rep_dn;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cur_d   = cur_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && !en_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        val_d   = load_clean;
        cur_d   = '0;
        err_d   = load_bad;
        state_d = S_EDIT;
      end
      S_EDIT: begin
        // Value step uses the cursor as it was before any move this cycle.
        if (do_up)      val_d[off +: 8] = up_fld;
        else if (do_dn) val_d[off +: 8] = dn_fld;
        if (r_e && !l_e)      cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + CUR_W'(1);
        else if (l_e && !r_e) cur_d = (cur_q == '0) ? CUR_LAST : cur_q - CUR_W'(1);
        if (!en) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // en history resets high so that an en level still asserted when reset
  // releases does not count as a new session start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b1;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
      val_q   <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      up_q    <= bt_up;
      dn_q    <= bt_down;
      l_q     <= bt_l;
      r_q     <= bt_r;
      val_q   <= val_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  assign edit_val = val_q;
  assign cursor   = cur_q;
  assign busy     = (state_q == S_LOAD) || (state_q == S_EDIT);
  assign commit   = (state_q == S_COMMIT);
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_field_editor.sv
// tb/tb_bcd_field_editor.sv - scoreboard testbench for bcd_field_editor
module tb_bcd_field_editor;

  localparam int DLY = 4;
  localparam int PER = 2;

  logic        clk = 1'b0;
  logic        reset, en, bt_up, bt_down, bt_l, bt_r;
  logic [23:0] load_val;
  logic [23:0] edit_val;
  logic [2:0]  cursor;
  logic        busy, commit, load_err;

  always #5 clk = ~clk;

  bcd_field_editor #(
    .NFIELD(3), .MAXV(24'h235959), .MINV(24'h000000),
    .REP_DLY(DLY), .REP_PER(PER)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .load_val(load_val),
    .bt_up(bt_up), .bt_down(bt_down), .bt_l(bt_l), .bt_r(bt_r),
    .edit_val(edit_val), .cursor(cursor), .busy(busy),
    .commit(commit), .load_err(load_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fields held as plain decimal integers.
  int MAXI[3] = '{23, 59, 59};
  int MINI[3] = '{0, 0, 0};
  int m_phase;               // 0 idle, 1 load, 2 edit, 3 commit
  int m_val[3];
  int m_cur;
  bit m_err;
  bit m_enp, m_up, m_dn, m_l, m_r;
  int m_rep, m_rn;

  typedef struct {
    logic [23:0] val;
    logic [2:0]  cur;
    logic        busy;
    logic        commit;
    logic        err;
  } snap_t;
  snap_t exp_q[$];

  task automatic model_reset();
    m_phase = 0;
    foreach (m_val[i]) m_val[i] = 0;
    m_cur = 0; m_err = 0;
    m_enp = 1; m_up = 0; m_dn = 0; m_l = 0; m_r = 0;
    m_rep = 0; m_rn = 0;
  endtask

  function automatic logic [23:0] m_packed();
    logic [23:0] res;
    for (int i = 0; i < 3; i++)
      res[8*(2-i) +: 8] = {4'(m_val[i] / 10), 4'(m_val[i] % 10)};
    return res;
  endfunction

  task automatic model_step();
    bit eu, ed, el, er;
    int step, f, w, nv;
    if (!reset) begin model_reset(); return; end
    eu = bt_up && !m_up;  ed = bt_down && !m_dn;
    el = bt_l && !m_l;    er = bt_r && !m_r;
    m_err = 0;
    step = 0;
    case (m_phase)
      0: begin
        m_rep = 0;
        if (en && !m_enp) m_phase = 1;
      end
      1: begin
        m_rep = 0;
        for (int i = 0; i < 3; i++) begin
          int hd, ld, v;
          hd = int'(load_val[8*(2-i)+4 +: 4]);
          ld = int'(load_val[8*(2-i) +: 4]);
          v  = hd * 10 + ld;
          if (hd > 9 || ld > 9 || v < MINI[i] || v > MAXI[i]) begin
            m_val[i] = MINI[i];
            m_err = 1;
          end else begin
            m_val[i] = v;
          end
        end
        m_cur = 0;
        m_phase = 2;
      end
      2: begin
        if (eu && !ed) step = 1;
        else if (ed && !eu) step = -1;
`ifdef BCD_EDIT_AUTOREPEAT_EN
        if (eu && !bt_down) begin m_rep = 1; m_rn = 0; end
        else if (ed && !bt_up) begin m_rep = -1; m_rn = 0; end
        else if ((m_rep == 1 && bt_up && !bt_down) || (m_rep == -1 && bt_down && !bt_up)) begin
          m_rn++;
          if (m_rn == DLY || (m_rn > DLY && (m_rn - DLY) % PER == 0)) step = m_rep;
        end else m_rep = 0;
`endif
        if (step != 0) begin
          f  = m_cur / 2;
          w  = (m_cur % 2 == 0) ? 10 : 1;
          nv = m_val[f] + step * w;
          if (step > 0 && (nv > 99 || nv > MAXI[f])) nv = MINI[f];
          if (step < 0 && (nv < 0 || nv < MINI[f])) nv = MAXI[f];
          m_val[f] = nv;
        end
        if (er && !el) m_cur = (m_cur + 1) % 6;
        else if (el && !er) m_cur = (m_cur + 5) % 6;
        if (!en) m_phase = 3;
      end
      default: begin
        m_rep = 0;
        m_phase = 0;
      end
    endcase
    m_enp = en; m_up = bt_up; m_dn = bt_down; m_l = bt_l; m_r = bt_r;
  endtask

  task automatic push_exp();
    snap_t s;
    s.val    = m_packed();
    s.cur    = 3'(m_cur);
    s.busy   = (m_phase == 1 || m_phase == 2);
    s.commit = (m_phase == 3);
    s.err    = m_err;
    exp_q.push_back(s);
  endtask

  // One clock: update the model from the inputs seen at this edge, then
  // drive the next inputs. An asserted reset acts at once on model and DUT.
  task automatic tick(input bit rs, input bit e, input bit u, input bit d, input bit l, input bit r);
    @(posedge clk);
    model_step();
    if (!rs) model_reset();
    push_exp();
    #1;
    reset = rs; en = e; bt_up = u; bt_down = d; bt_l = l; bt_r = r;
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    tick(1, 1, u, d, l, r);
    tick(1, 1, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic start_session(input logic [23:0] lv);
    load_val = lv;
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic end_session(input logic [23:0] final_val);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("commit_pulse", commit, 1);
    chk("commit_val", edit_val, final_val);
    tick(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("commit_end", commit, 0);
    chk("busy_after_commit", busy, 0);
  endtask

  function automatic logic [7:0] rand_bcd();
    return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction

  // Monitor: every cycle the DUT presents a state, compare with the model.
  bit done = 0;
  initial begin
    snap_t s;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("sb_edit_val", edit_val, s.val);
        chk("sb_cursor",   cursor,   s.cur);
        chk("sb_busy",     busy,     s.busy);
        chk("sb_commit",   commit,   s.commit);
        chk("sb_load_err", load_err, s.err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit ce, cu, cd, cl, cr, rs;
    reset = 1; en = 0; bt_up = 0; bt_down = 0; bt_l = 0; bt_r = 0; load_val = '0;
    model_reset();
    #2 reset = 0;
    #1;
    chk("reset_edit_val", edit_val, 0);
    chk("reset_cursor", cursor, 0);
    chk("reset_busy", busy, 0);
    chk("reset_commit", commit, 0);
    chk("reset_load_err", load_err, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);

    // Clean load.
    load_val = 24'h125930;
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("busy_in_load", busy, 1);
    tick(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("load_value", edit_val, 24'h125930);
    chk("load_cursor", cursor, 0);
    chk("load_err_clean", load_err, 0);
    end_session(24'h125930);

    // Stepping, wrapping and cursor moves.
    start_session(24'h231930);
    press(0, 0, 0, 1); chk("cursor_right", cursor, 1);
    press(1, 0, 0, 0); chk("up_past_max", edit_val[23:16], 8'h00);
    press(0, 1, 0, 0); chk("down_past_min", edit_val[23:16], 8'h23);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1); chk("cursor_3", cursor, 3);
    press(1, 0, 0, 0); chk("units_carry", edit_val[15:8], 8'h20);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0); chk("cursor_0", cursor, 0);
    press(0, 0, 1, 0); chk("cursor_wrap_left", cursor, 5);
    press(0, 0, 0, 1); chk("cursor_wrap_right", cursor, 0);
    press(1, 1, 0, 0); chk("up_down_cancel", edit_val, 24'h232030);
    press(1, 0, 0, 1);
    chk("step_with_move_val", edit_val[23:16], 8'h00);
    chk("step_with_move_cur", cursor, 1);
    press(0, 0, 1, 1); chk("left_right_cancel", cursor, 1);
    end_session(24'h002030);

    // Illegal fields on load.
    start_session(24'h2A6007);
    chk("illegal_load_val", edit_val, 24'h000007);
    chk("illegal_load_err", load_err, 1);
    press(0, 0, 0, 1);
    chk("load_err_one_cycle", load_err, 0);

    // Asynchronous reset mid-session, en still held afterwards.
    tick(0, 1, 0, 0, 0, 0);
    #1;
    chk("async_rst_edit_val", edit_val, 0);
    chk("async_rst_cursor", cursor, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_commit", commit, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("no_restart_busy", busy, 0);
    chk("no_restart_commit", commit, 0);
    tick(1, 0, 0, 0, 0, 0);

    // Held up button on the units digit.
    start_session(24'h000000);
    press(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick(1, 1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    @(negedge clk);
`ifdef BCD_EDIT_AUTOREPEAT_EN
    chk("autorepeat_hold", edit_val[23:16], 8'h04);
`else
    chk("hold_single_step", edit_val[23:16], 8'h01);
`endif
    end_session({edit_val[23:16], 16'h0000});

    // Randomised stimulus.
    ce = 0; cu = 0; cd = 0; cl = 0; cr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) ce = !ce;
      if ($urandom_range(0, 3) == 0) cu = !cu;
      if ($urandom_range(0, 3) == 0) cd = !cd;
      if ($urandom_range(0, 3) == 0) cl = !cl;
      if ($urandom_range(0, 3) == 0) cr = !cr;
      rs = ($urandom_range(0, 399) != 0);
      tick(rs, ce, cu, cd, cl, cr);
      load_val = ($urandom_range(0, 3) == 0) ? 24'($urandom) : {rand_bcd(), rand_bcd(), rand_bcd()};
    end

    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
